// File: rtl/flt2int.sv
// flt2int: converts a half-precision float held in data memory into a 16-bit
// two's-complement integer (truncated toward zero) and writes it back.
//
// A 0->1 transition on start (accepted only when idle or done) reads the two
// float bytes at SRC_ADDR/SRC_ADDR+1 and decodes them. The magnitude is then
// shifted one bit per cycle into place, and the result is written to
// DST_ADDR/DST_ADDR+1.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        request line, rising edge launches a conversion
//   done         high once the result is written, until the next accepted start
//   mem_addr     data-memory byte address
//   mem_rd_data  combinational read data for mem_addr
//   mem_wr_en    write strobe (memory writes on rising clk)
//   mem_wr_data  write data
module flt2int #(
    parameter logic [7:0] SRC_ADDR = 8'd0,
    parameter logic [7:0] DST_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, DECODE, SHIFT, WR_LO, WR_HI, DONE
    } state_t;

    state_t      state, next_state;
    logic        start_d;
    logic [7:0]  flt_lo, flt_hi;
    logic [15:0] mag;
    logic [4:0]  cnt;
    logic        neg;      // negate the magnitude on write-back
    logic        left;     // shift direction for the SHIFT phase

    logic        start_edge;
    assign start_edge = start & ~start_d;

    // Decode of the captured float into initial magnitude, shift count and
    // direction. Saturation loads the final pattern directly with neg=0 so
    // the write-back path never negates it.
    logic [4:0]  expo;
    logic [15:0] base;
    logic [15:0] dec_mag;
    logic [4:0]  dec_n;
    logic        dec_neg, dec_left;

    assign expo = flt_hi[6:2];
    assign base = {5'b0, 1'b1, flt_hi[1:0], flt_lo};

    always_comb begin
        dec_mag  = 16'h0000;
        dec_n    = 5'd0;
        dec_neg  = 1'b0;
        dec_left = 1'b0;
        if (expo <= 5'd14) begin
            // zero, subnormal or |x| < 1: truncates to 0 (also covers -0)
            dec_mag = 16'h0000;
        end else if (expo <= 5'd24) begin
            dec_mag = base;
            dec_n   = 5'd25 - expo;
            dec_neg = flt_hi[7];
        end else if (expo <= 5'd29) begin
            dec_mag  = base;
            dec_n    = expo - 5'd25;
            dec_neg  = flt_hi[7];
            dec_left = 1'b1;
        end else begin
            dec_mag = flt_hi[7] ? 16'h8000 : 16'h7FFF;
        end
    end

    logic [15:0] result;
    assign result = neg ? (~mag + 16'd1) : mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        mem_addr    = SRC_ADDR;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) next_state = RD_LO;
            end
            RD_LO: begin
                mem_addr   = SRC_ADDR;
                next_state = RD_HI;
            end
            RD_HI: begin
                mem_addr   = SRC_ADDR + 8'd1;
                next_state = DECODE;
            end
            DECODE: begin
                next_state = (dec_n != 5'd0) ? SHIFT : WR_LO;
            end
            SHIFT: begin
                // cnt holds the shifts still to do, including this cycle's
                if (cnt <= 5'd1) next_state = WR_LO;
            end
            WR_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = DST_ADDR;
                mem_wr_data = result[7:0];
                next_state  = WR_HI;
            end
            WR_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = DST_ADDR + 8'd1;
                mem_wr_data = result[15:8];
                next_state  = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start_edge) next_state = RD_LO;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_d <= 1'b0;
            flt_lo  <= 8'h00;
            flt_hi  <= 8'h00;
            mag     <= 16'h0000;
            cnt     <= 5'd0;
            neg     <= 1'b0;
            left    <= 1'b0;
        end else begin
            start_d <= start;
            case (state)
                RD_LO: flt_lo <= mem_rd_data;
                RD_HI: flt_hi <= mem_rd_data;
                DECODE: begin
                    mag  <= dec_mag;
                    cnt  <= dec_n;
                    neg  <= dec_neg;
                    left <= dec_left;
                end
                SHIFT: begin
                    mag <= left ? {mag[14:0], 1'b0} : {1'b0, mag[15:1]};
                    cnt <= cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
